olr2k_add: RTL and testbench

- Parametrised successor to the fixed radix-4 online adder.
- Most-significant-digit-first (online) adder for radix r = 2^K, operating on LANES independent digit streams in lockstep.
- Digit set is maximally redundant, {-(r-1)..r-1}, signed two's complement, DW = K+1 bits.
- Adds operand framing (first/last), stall support, an automatic flush of the final digit, an overflow digit s_{-1}, and sticky protocol-error detection. Sits in the MSDF datapath between digit-serial producers and consumers.

---
 rtl/olr2k_pkg.sv | 16 +
 rtl/olr2k_digit_tw.sv | 24 ++
 rtl/olr2k_add.sv | 63 ++++++
 tb/tb_olr2k_add.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/olr2k_pkg.sv
// olr2k_pkg: shared digit width/radix helpers, digit-set bounds and FSM encoding for the online adder
package olr2k_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;
  function automatic int dw(input int k);
    return k + 1;
  endfunction
  function automatic int radix(input int k);
    return 1 << k;
  endfunction
  function automatic int dig_max(input int k);
    return (1 << k) - 1;
  endfunction
  function automatic int dig_min(input int k);
    return 1 - (1 << k);
  endfunction
endpackage

// File: rtl/olr2k_digit_tw.sv
// olr2k_digit_tw: per-lane split of x_i+y_i into transfer t_o (+1/0/-1, 2-bit two's complement) and interim w_o, bad_o flags a -2^K input digit
module olr2k_digit_tw import olr2k_pkg::*; #(
  parameter int K = 2,
  localparam int DW = dw(K)
) (
  input  logic [DW-1:0] x_i,
  input  logic [DW-1:0] y_i,
  output logic [1:0]    t_o,
  output logic [DW-1:0] w_o,
  output logic          bad_o
);
  localparam logic signed [DW:0] HI = (DW+1)'(dig_max(K));
  localparam logic signed [DW:0] R = (DW+1)'(radix(K));
  localparam logic [DW-1:0] NEG = {1'b1, {K{1'b0}}};
  logic signed [DW:0] z;
  logic signed [DW:0] wz;
  always_comb begin
    z = $signed({x_i[DW-1], x_i}) + $signed({y_i[DW-1], y_i});
    wz = z >= HI ? z - R : z <= -HI ? z + R : z;
    t_o = z >= HI ? 2'b01 : z <= -HI ? 2'b11 : 2'b00;
    w_o = wz[DW-1:0];
    bad_o = (x_i == NEG) || (y_i == NEG);
  end
endmodule

// File: rtl/olr2k_add.sv
// olr2k_add: MSDF online adder, radix 2^K, LANES lockstep streams; in: clk, reset(async low), in_valid/first/last, x, y; out: s, out_valid/first/last, err(sticky)
module olr2k_add import olr2k_pkg::*; #(
  parameter int K = 2,
  parameter int LANES = 1,
  localparam int DW = dw(K)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic [LANES*DW-1:0]   x,
  input  logic [LANES*DW-1:0]   y,
  output logic [LANES*DW-1:0]   s,
  output logic                  out_valid,
  output logic                  out_first,
  output logic                  out_last,
  output logic                  err
);
  state_e state_q, state_d;
  logic [LANES*DW-1:0] w, wprev_q, wprev_d, s_d;
  logic [LANES-1:0] bad;
  logic accept, flush, proto_err;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [1:0] t;
    olr2k_digit_tw #(.K(K)) u_tw (
      .x_i  (x[i*DW +: DW]),
      .y_i  (y[i*DW +: DW]),
      .t_o  (t),
      .w_o  (w[i*DW +: DW]),
      .bad_o(bad[i])
    );
    // flush emits the held interim digit with no incoming transfer
    assign s_d[i*DW +: DW] = wprev_q[i*DW +: DW] + (flush ? DW'(0) : {{(DW-2){t[1]}}, t});
  end
  always_comb begin
    flush = state_q == FLUSH;
    accept = in_valid & (state_q == IDLE ? in_first : (state_q == RUN) & ~in_first);
    // every valid beat that is not accepted is a protocol violation
    proto_err = in_valid & ~accept;
    wprev_d = flush ? '0 : accept ? w : wprev_q;
    state_d = flush ? IDLE : accept ? (in_last ? FLUSH : RUN) : state_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wprev_q <= '0;
      s <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last <= 1'b0;
      err <= 1'b0;
    end else begin
      state_q <= state_d;
      wprev_q <= wprev_d;
      out_valid <= accept | flush;
      out_first <= accept & (state_q == IDLE);
      out_last <= flush;
      if (accept | flush) s <= s_d;
      if (proto_err | (accept & |bad)) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_olr2k_add.sv
// tb_olr2k_add: directed K=2 checks and randomized K=3 x4-lane frames against a value-level reference model
module tb_olr2k_add;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  logic v2 = 0, f2 = 0, l2 = 0;
  logic [2:0] x2 = '0, y2 = '0, s2;
  logic ov2, of2, ol2, e2;
  logic v3 = 0, f3 = 0, l3 = 0;
  logic [15:0] x3 = '0, y3 = '0, s3;
  logic ov3, of3, ol3, e3;
  int checks = 0;
  int errors = 0;
  longint acc[4];
  int cnt;
  int cur_n;
  olr2k_add #(.K(2), .LANES(1)) u2 (
    .clk(clk), .reset(reset), .in_valid(v2), .in_first(f2), .in_last(l2),
    .x(x2), .y(y2), .s(s2), .out_valid(ov2), .out_first(of2), .out_last(ol2), .err(e2)
  );
  olr2k_add #(.K(3), .LANES(4)) u3 (
    .clk(clk), .reset(reset), .in_valid(v3), .in_first(f3), .in_last(l3),
    .x(x3), .y(y3), .s(s3), .out_valid(ov3), .out_first(of3), .out_last(ol3), .err(e3)
  );
  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cyc2(input logic v, input logic f, input logic l, input int xd, input int yd);
    v2 = v;
    f2 = f;
    l2 = l;
    x2 = 3'(xd);
    y2 = 3'(yd);
    @(posedge clk);
    #1;
  endtask
  task automatic o2(input string tag, input logic v, input logic f, input logic l, input int d);
    chk({tag, "_valid"}, ov2, v);
    chk({tag, "_first"}, of2, f);
    chk({tag, "_last"}, ol2, l);
    if (v) chk({tag, "_digit"}, $signed(s2), d);
  endtask
  task automatic collect();
    if (ov3) begin
      chk("rnd_first", of3, cnt == 0);
      chk("rnd_last", ol3, cnt == cur_n);
      for (int l = 0; l < 4; l++) begin
        logic [3:0] dg;
        int d;
        dg = s3[l*4 +: 4];
        d = int'($signed(dg));
        chk("rnd_range", (d >= -7) && (d <= 7), 1);
        acc[l] = acc[l] * 8 + longint'(d);
      end
      cnt++;
    end
  endtask
  task automatic cyc3(input logic v, input logic f, input logic l, input logic [15:0] xv, input logic [15:0] yv);
    v3 = v;
    f3 = f;
    l3 = l;
    x3 = xv;
    y3 = yv;
    @(posedge clk);
    #1;
    collect();
  endtask
  initial begin
    int sx[3];
    int sy[3];
    int se[4];
    sx = '{1, 2, -3};
    sy = '{2, 1, 3};
    se = '{1, 0, -1, 0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s2", s2, 0);
    chk("rst_valid2", ov2, 0);
    chk("rst_first2", of2, 0);
    chk("rst_last2", ol2, 0);
    chk("rst_err2", e2, 0);
    chk("rst_s3", s3, 0);
    chk("rst_err3", e3, 0);
    reset = 1'b1;
    cyc2(0, 0, 0, 0, 0);
    o2("idle", 0, 0, 0, 0);
    cyc2(1, 1, 0, 3, 3);
    o2("ex1_m1", 1, 1, 0, 1);
    cyc2(1, 0, 1, 3, 3);
    o2("ex1_0", 1, 0, 0, 3);
    cyc2(0, 0, 0, 0, 0);
    o2("ex1_1", 1, 0, 1, 2);
    cyc2(1, 1, 0, 1, 1);
    o2("ex2_m1", 1, 1, 0, 0);
    cyc2(1, 0, 1, -2, 0);
    o2("ex2_0", 1, 0, 0, 2);
    cyc2(0, 0, 0, 0, 0);
    o2("ex2_1", 1, 0, 1, -2);
    cyc2(1, 1, 1, -3, 0);
    o2("n1_m1", 1, 1, 0, -1);
    cyc2(0, 0, 0, 0, 0);
    o2("n1_0", 1, 0, 1, 1);
    cyc2(0, 0, 0, 0, 0);
    o2("n1_after", 0, 0, 0, 0);
    chk("err_clean", e2, 0);
    for (int i = 0; i < 3; i++) begin
      cyc2(1, i == 0, i == 2, sx[i], sy[i]);
      o2($sformatf("nostall_%0d", i), 1, i == 0, 0, se[i]);
    end
    cyc2(0, 0, 0, 0, 0);
    o2("nostall_3", 1, 0, 1, se[3]);
    for (int i = 0; i < 2; i++) begin
      cyc2(1, i == 0, 0, sx[i], sy[i]);
      o2($sformatf("stall_%0d", i), 1, i == 0, 0, se[i]);
    end
    cyc2(0, 0, 0, 0, 0);
    o2("stall_gap0", 0, 0, 0, 0);
    cyc2(0, 0, 0, 0, 0);
    o2("stall_gap1", 0, 0, 0, 0);
    cyc2(1, 0, 1, sx[2], sy[2]);
    o2("stall_2", 1, 0, 0, se[2]);
    cyc2(0, 0, 0, 0, 0);
    o2("stall_3", 1, 0, 1, se[3]);
    chk("err_stall", e2, 0);
    cyc2(1, 0, 0, 1, 1);
    o2("drop_idle", 0, 0, 0, 0);
    chk("err_idle", e2, 1);
    cyc2(1, 1, 1, 1, 1);
    o2("pf_m1", 1, 1, 0, 0);
    cyc2(1, 1, 1, 3, 3);
    o2("pf_flush", 1, 0, 1, 2);
    cyc2(0, 0, 0, 0, 0);
    o2("pf_dropped", 0, 0, 0, 0);
    chk("err_flush", e2, 1);
    cyc2(1, 1, 0, 3, 3);
    o2("post_m1", 1, 1, 0, 1);
    cyc2(1, 0, 1, 3, 3);
    o2("post_0", 1, 0, 0, 3);
    cyc2(0, 0, 0, 0, 0);
    o2("post_1", 1, 0, 1, 2);
    chk("err_held", e2, 1);
    cyc2(1, 1, 0, 3, 3);
    o2("ab_m1", 1, 1, 0, 1);
    f2 = 0;
    #2;
    reset = 1'b0;
    #1;
    chk("ab_s", s2, 0);
    chk("ab_valid", ov2, 0);
    chk("ab_first", of2, 0);
    chk("ab_last", ol2, 0);
    chk("ab_err", e2, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc2(1, 1, 1, 3, 3);
    o2("rs_m1", 1, 1, 0, 1);
    cyc2(0, 0, 0, 0, 0);
    o2("rs_0", 1, 0, 1, 2);
    chk("rnd_err0", e3, 0);
    for (int fr = 0; fr < 20; fr++) begin
      int xd[16][4];
      int yd[16][4];
      longint ex[4];
      cur_n = $urandom_range(1, 16);
      cnt = 0;
      for (int l = 0; l < 4; l++) begin
        acc[l] = 0;
        ex[l] = 0;
      end
      for (int j = 0; j < cur_n; j++)
        for (int l = 0; l < 4; l++) begin
          xd[j][l] = int'($urandom_range(0, 14)) - 7;
          yd[j][l] = int'($urandom_range(0, 14)) - 7;
          ex[l] = ex[l] * 8 + longint'(xd[j][l] + yd[j][l]);
        end
      for (int j = 0; j < cur_n; j++) begin
        logic [15:0] xv, yv;
        while ($urandom_range(0, 3) == 0) cyc3(0, 0, 0, '0, '0);
        for (int l = 0; l < 4; l++) begin
          xv[l*4 +: 4] = 4'(xd[j][l]);
          yv[l*4 +: 4] = 4'(yd[j][l]);
        end
        cyc3(1, j == 0, j == cur_n - 1, xv, yv);
      end
      cyc3(0, 0, 0, '0, '0);
      chk($sformatf("rnd_count_f%0d", fr), cnt, cur_n + 1);
      for (int l = 0; l < 4; l++) chk($sformatf("rnd_sum_f%0d_l%0d", fr, l), acc[l], ex[l]);
    end
    chk("rnd_err_legal", e3, 0);
    cur_n = 1;
    cnt = 0;
    for (int l = 0; l < 4; l++) acc[l] = 0;
    cyc3(1, 1, 1, 16'h0800, 16'h0000);
    cyc3(0, 0, 0, '0, '0);
    chk("inject_count", cnt, 2);
    chk("inject_err", e3, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
